// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with midpoint sampling, one-cycle valid and framing-error strobes.
// Define UART_RX_PARITY_EN to receive an even-parity bit between the data and stop bits.
module uart_rx #(
    parameter int TICKS_PER_BIT      = 32,
    parameter int TICKS_PER_BIT_SIZE = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_din,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_parity_err
);
    localparam logic [6:0] IDLE   = 7'b0000001;
    localparam logic [6:0] START  = 7'b0000010;
    localparam logic [6:0] BITS   = 7'b0000100;
`ifdef UART_RX_PARITY_EN
    localparam logic [6:0] PARITY = 7'b0001000;
`endif
    localparam logic [6:0] STOP   = 7'b0010000;
    localparam logic [6:0] DONE   = 7'b0100000;
    localparam logic [6:0] ERR    = 7'b1000000;
`ifdef UART_RX_PARITY_EN
    localparam logic [6:0] AFTER_BITS = PARITY;
`else
    localparam logic [6:0] AFTER_BITS = STOP;
`endif
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_HALF = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT / 2 - 1);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_END  = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);

    logic                          rx_m, rx_s, rx_prev;
    logic [6:0]                    state, state_nx;
    logic [TICKS_PER_BIT_SIZE-1:0] tick;
    logic [2:0]                    bit_cnt;
    logic [7:0]                    shift;
    logic                          tick_end, counting;

    assign tick_end = tick == TICK_END;
    assign o_busy   = state != IDLE;
`ifdef UART_RX_PARITY_EN
    assign counting = state inside {START, BITS, PARITY, STOP};
`else
    assign counting = state inside {START, BITS, STOP};
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (rx_prev && !rx_s) state_nx = START;
            START:  if (tick == TICK_HALF) state_nx = rx_s ? IDLE : BITS;
            BITS:   if (tick_end && bit_cnt == 3'd7) state_nx = AFTER_BITS;
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick_end) state_nx = STOP;
`endif
            STOP:   if (tick_end) state_nx = rx_s ? DONE : ERR;
            DONE:   state_nx = IDLE;
            ERR:    if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The byte is loaded on entry to DONE so o_data is already valid while o_valid is high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            {rx_m, rx_s, rx_prev} <= 3'b111;
            state       <= IDLE;
            tick        <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_m        <= i_din;
            rx_s        <= rx_m;
            rx_prev     <= rx_s;
            state       <= state_nx;
            tick        <= (!counting || state_nx != state || tick_end) ? '0 : tick + TICKS_PER_BIT_SIZE'(1);
            bit_cnt     <= (state != BITS) ? '0 : bit_cnt + 3'(tick_end);
            if (state == BITS && tick_end) shift <= {rx_s, shift[7:1]};
            if (state_nx == DONE) o_data <= shift;
            o_valid     <= state_nx == DONE;
            o_frame_err <= state == STOP && state_nx == ERR;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            par_bad      <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            if (state == PARITY && tick_end) par_bad <= ^{shift, rx_s};
            o_parity_err <= state_nx == DONE && par_bad;
        end
    end
`else
    assign o_parity_err = 1'b0;
`endif
endmodule
